// File: rtl/karatsuba_pkg.sv
// Shared definitions for the Karatsuba combine/reduce pipeline: default
// operand width, reduction polynomial, derived widths and a carry-less multiply.
package karatsuba_pkg;

    localparam int          DEF_W    = 32;
    localparam logic [63:0] DEF_POLY = 64'h1B;

    localparam int PW = 2 * DEF_W - 1;
    localparam int YW = 4 * DEF_W - 1;

    // Working width of clmul; callers zero-extend into it, so W may go up to 64.
    localparam int CLW = 128;

    function automatic logic [2*CLW-1:0] clmul(input logic [CLW-1:0] a,
                                               input logic [CLW-1:0] b);
        logic [2*CLW-1:0] prod;
        prod = '0;
        for (int i = 0; i < CLW; i++) begin
            if (b[i]) begin
                prod = prod ^ ({{CLW{1'b0}}, a} << i);
            end
        end
        return prod;
    endfunction

endpackage

// File: rtl/gf2_reduce.sv
// Combinational reduction of a (4W-1)-bit carry-less product modulo x^(2W)+g
// using two folds; the second fold is exact because deg(g) < W.
module gf2_reduce
    import karatsuba_pkg::*;
#(
    parameter int             W    = DEF_W,
    parameter logic [2*W-1:0] POLY = (2*W)'(DEF_POLY)
) (
    input  logic [4*W-2:0] p,
    output logic [2*W-1:0] r
);

    logic [2*CLW-1:0] r1;

    assign r1 = clmul(CLW'(p[4*W-2:2*W]), CLW'(POLY)) ^ (2*CLW)'(p[2*W-1:0]);

    // Whatever fold 1 leaves at x^(2W) and above has degree < W-2, so one more fold lands below x^(2W).
    assign r = (2*W)'(r1) ^ (2*W)'(clmul(CLW'(r1 >> (2*W)), CLW'(POLY)));

endmodule

// File: rtl/karatsuba_combine_pipe.sv
// Two-stage pipeline: stage 1 combines the Karatsuba partial products, stage 2
// optionally reduces modulo x^(2W)+g and folds the result into an accumulator.
module karatsuba_combine_pipe
    import karatsuba_pkg::*;
#(
    parameter int             W    = DEF_W,
    parameter logic [2*W-1:0] POLY = (2*W)'(DEF_POLY)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*W-2:0] z0,
    input  logic [2*W-2:0] z1,
    input  logic [2*W-2:0] z2,
    input  logic           mode,
    input  logic           acc_en,
    input  logic           acc_clr,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [4*W-2:0] y
);

    // Handshake: a beat moves across a boundary on a cycle where valid && ready
    // are both high; each stage loads when empty or when its own beat leaves in
    // that same cycle. Ready never looks at the matching valid.
    logic           s1_valid;
    logic [4*W-2:0] s1_p;
    logic           s1_mode;
    logic           s1_acc_en;
    logic           s1_acc_clr;
    logic           s2_ready;

    logic [2*W-1:0] acc;
    logic [2*W-1:0] r;
    logic [2*W-1:0] acc_next;
    logic [4*W-2:0] p_next;
    logic [4*W-2:0] y_next;

    assign s2_ready = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_ready;

    assign p_next = (4*W-1)'(z0)
                  ^ ((4*W-1)'(z0 ^ z1 ^ z2) << W)
                  ^ ((4*W-1)'(z2) << (2*W));

    gf2_reduce #(
        .W    (W),
        .POLY (POLY)
    ) u_reduce (
        .p (s1_p),
        .r (r)
    );

    assign acc_next = r ^ (s1_acc_clr ? '0 : acc);

    always_comb begin
        y_next = s1_p;
        if (s1_mode) begin
            y_next = (4*W-1)'(s1_acc_en ? acc_next : r);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            out_valid <= 1'b0;
            y         <= '0;
            acc       <= '0;
        end else begin
            if (in_ready) begin
                s1_valid <= in_valid;
            end
            if (s2_ready) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    y <= y_next;
                    if (s1_mode && s1_acc_en) begin
                        acc <= acc_next;
                    end
                end
            end
        end
    end

    // Stage-1 payload needs no reset: it is only observed behind s1_valid.
    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            s1_p       <= p_next;
            s1_mode    <= mode;
            s1_acc_en  <= acc_en;
            s1_acc_clr <= acc_clr;
        end
    end

endmodule

// File: tb/tb_karatsuba_combine_pipe.sv
// Directed and randomized checks of karatsuba_combine_pipe (W=32, g=0x1B)
// against a long-division reference model and an in-order expected queue.
module tb_karatsuba_combine_pipe;
    import karatsuba_pkg::*;

    localparam int           W  = 32;
    localparam logic [126:0] G  = 127'h1B;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [62:0]  z0, z1, z2;
    logic         mode, acc_en, acc_clr;
    logic         out_valid;
    logic         out_ready;
    logic [126:0] y;

    int           checks = 0;
    int           errors = 0;
    int           n_out  = 0;
    int           n_in   = 0;
    logic [126:0] exp_q[$];
    logic [63:0]  m_acc;
    logic         stall_prev;
    logic [126:0] held_y;
    logic [63:0]  held_acc;

    always #5 clk = ~clk;

    karatsuba_combine_pipe #(.W(W), .POLY(64'h1B)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .z0        (z0),
        .z1        (z1),
        .z2        (z2),
        .mode      (mode),
        .acc_en    (acc_en),
        .acc_clr   (acc_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [126:0] ref_p(input logic [62:0] a, input logic [62:0] b,
                                           input logic [62:0] c);
        return 127'(a) ^ (127'(a ^ b ^ c) << 32) ^ (127'(c) << 64);
    endfunction

    // Bit-serial long division by x^64 + g.
    function automatic logic [63:0] ref_reduce(input logic [126:0] p);
        logic [126:0] t;
        t = p;
        for (int i = 126; i >= 64; i--) begin
            if (t[i]) begin
                t = t ^ ((127'(1) << i) | (G << (i - 64)));
            end
        end
        return t[63:0];
    endfunction

    task automatic push_expected();
        logic [126:0] p;
        logic [63:0]  r;
        p = ref_p(z0, z1, z2);
        if (!mode) begin
            exp_q.push_back(p);
        end else begin
            r = ref_reduce(p);
            if (acc_en) begin
                r = r ^ (acc_clr ? 64'h0 : m_acc);
                m_acc = r;
            end
            exp_q.push_back(127'(r));
        end
    endtask

    // One clock: monitor at the falling edge, then return just after the rising edge.
    task automatic step();
        logic [126:0] e;
        @(negedge clk);
        if (stall_prev) begin
            chk("hold_valid", 128'(out_valid), 128'(1));
            chk("hold_y", 128'(y), 128'(held_y));
            chk("hold_acc", 128'(dut.acc), 128'(held_acc));
        end
        if (out_valid && out_ready) begin
            n_out++;
            chk("out_has_expected", 128'(exp_q.size() > 0), 128'(1));
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("y", 128'(y), 128'(e));
            end
        end
        stall_prev = out_valid && !out_ready;
        held_y     = y;
        held_acc   = dut.acc;
        if (in_valid && in_ready) begin
            n_in++;
            push_expected();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
            step();
        end
        chk("drain_empty", 128'(exp_q.size()), 128'(0));
    endtask

    task automatic rand_beat();
        z0      = 63'({$urandom, $urandom});
        z1      = 63'({$urandom, $urandom});
        z2      = 63'({$urandom, $urandom});
        mode    = 1'($urandom_range(0, 1));
        acc_en  = 1'($urandom_range(0, 1));
        acc_clr = ($urandom_range(0, 3) == 0);
    endtask

    initial begin
        int n0;
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        z0 = '0; z1 = '0; z2 = '0; mode = 1'b0; acc_en = 1'b0; acc_clr = 1'b0;
        m_acc = '0; stall_prev = 1'b0; held_y = '0; held_acc = '0;

        // reset state
        #1 rst = 1'b1;
        #1;
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_y", 128'(y), 128'(0));
        chk("rst_acc", 128'(dut.acc), 128'(0));
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1 chk("post_rst_in_ready", 128'(in_ready), 128'(1));

        // raw product, latency 2
        in_valid = 1'b1; z0 = 63'd1; z1 = '0; z2 = '0; mode = 1'b0;
        step();
        in_valid = 1'b0;
        #3 chk("lat_cycle1_idle", 128'(out_valid), 128'(0));
        step();
        #3 chk("lat_cycle2_valid", 128'(out_valid), 128'(1));
        chk("raw_y_const", 128'(y), 128'(127'h1_0000_0001));
        step();

        // reduced, no accumulate
        in_valid = 1'b1; z0 = '0; z2 = 63'd1; mode = 1'b1; acc_en = 1'b0;
        step();
        in_valid = 1'b0;
        step();
        #3 chk("red_y_const", 128'(y), 128'(127'h1_0000_001B));
        drain();

        // accumulate two beats, first clears
        in_valid = 1'b1; z0 = 63'd1; z1 = '0; z2 = '0; mode = 1'b1; acc_en = 1'b1; acc_clr = 1'b1;
        step();
        acc_clr = 1'b0;
        step();
        in_valid = 1'b0;
        #3 chk("acc_first_y", 128'(y), 128'(127'h1_0000_0001));
        step();
        #3 chk("acc_second_y", 128'(y), 128'(0));
        drain();
        chk("acc_final", 128'(dut.acc), 128'(0));

        // random stream with random backpressure
        n0 = n_in;
        for (int c = 0; c < 2000 && n_in < n0 + 60; c++) begin
            rand_beat();
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            step();
        end
        chk("rand_accepted", 128'(n_in - n0), 128'(60));
        drain();

        // reset while both stages are full and stalled
        out_ready = 1'b0; in_valid = 1'b1; rand_beat(); mode = 1'b1; acc_en = 1'b1; acc_clr = 1'b1;
        z0 = 63'h1234_5678_9ABC;
        step();
        rand_beat(); mode = 1'b1; acc_en = 1'b1; acc_clr = 1'b0;
        step();
        in_valid = 1'b0;
        #3 chk("pre_rst_full", 128'(out_valid && dut.s1_valid), 128'(1));
        rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", 128'(out_valid), 128'(0));
        chk("mid_rst_s1_valid", 128'(dut.s1_valid), 128'(0));
        chk("mid_rst_acc", 128'(dut.acc), 128'(0));
        chk("mid_rst_y", 128'(y), 128'(0));
        exp_q.delete();
        m_acc = '0;
        stall_prev = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        #1 chk("rel_in_ready", 128'(in_ready), 128'(1));
        out_ready = 1'b1; in_valid = 1'b1; rand_beat(); mode = 1'b1; acc_en = 1'b1; acc_clr = 1'b0;
        step();
        drain();

        // full-rate streaming
        n0 = n_out;
        out_ready = 1'b1;
        for (int i = 0; i < 102; i++) begin
            rand_beat();
            in_valid = (i < 100);
            if (i < 100) chk("tp_in_ready", 128'(in_ready), 128'(1));
            if (i >= 2) chk("tp_out_valid", 128'(out_valid), 128'(1));
            step();
        end
        chk("tp_count", 128'(n_out - n0), 128'(100));
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/karatsuba_combine_pipe.md
KARATSUBA_COMBINE_PIPE -- requirements
Module: karatsuba_combine_pipe

Interface
REQ-001 Parameter W, default 32: half operand width; z0/z1/z2 are 2W-1 bits wide and the product is 4W-1 bits wide.
REQ-002 Parameter POLY, default 64'h1B: low terms g of the reduction polynomial x^(2W)+g, width 2W, with deg(g) < W.
REQ-003 Clocking: one clock, clk; reset rst is asynchronous and active-high.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 in_valid  in  1  input beat valid.
REQ-007 in_ready  out  1  block accepts the beat this cycle.
REQ-008 z0  in  2W-1  carry-less product AL*BL.
REQ-009 z1  in  2W-1  carry-less product (AL^AH)*(BL^BH).
REQ-010 z2  in  2W-1  carry-less product AH*BH.
REQ-011 mode  in  1  0 = raw product, 1 = reduced mod x^(2W)+g.
REQ-012 acc_en  in  1  XOR the reduced result into the accumulator (only when mode=1).
REQ-013 acc_clr  in  1  treat the accumulator as zero for this beat.
REQ-014 out_valid  out  1  output beat valid.
REQ-015 out_ready  in  1  downstream accepts the beat.
REQ-016 y  out  4W-1  result; zero-extended when mode=1.

Function
REQ-017 Stage 1 SHALL register P = z0 ^ ((z0^z1^z2)<<W) ^ (z2<<2W), which is 4W-1 bits, together with mode, acc_en and acc_clr.
REQ-018 Stage 2 SHALL compute R = P mod (x^(2W)+g) using two folds:
- fold 1: R1 = P[2W-1:0] ^ clmul(P[4W-2:2W], g);
- fold 2: fold the bits of R1 at 2W and above once more.
REQ-019 When mode=1 and acc_en=1, stage 2 SHALL output R ^ (acc_clr ? 0 : acc) and load that value into acc.
- When mode=1 and acc_en=0, stage 2 SHALL output R and leave acc unchanged.
- When mode=0, stage 2 SHALL output P and leave acc unchanged.
REQ-020 Latency SHALL be exactly 2 cycles from input acceptance to out_valid when no stall occurs; throughput SHALL be one beat per cycle.
REQ-021 Transfer rule: a transfer occurs on a cycle where valid&&ready; a stage loads when it is empty or its contents transfer that same cycle.
REQ-022 in_ready SHALL equal !s1_valid || (!out_valid || out_ready).
- in_ready SHALL NOT depend on in_valid.
REQ-023 While out_valid=1 and out_ready=0, y, out_valid and acc SHALL hold stable.
- The stage-1 beat SHALL hold as well; no beat is dropped or duplicated.
REQ-024 Simultaneous accept and drain with both stages full SHALL sustain full rate with ordering preserved.
REQ-025 acc SHALL update only when stage 2 loads a beat with mode=1 and acc_en=1, never during a stall.
REQ-026 When acc_en=0, acc_clr SHALL be ignored.

Reset
REQ-027 While rst is high, s1_valid, out_valid and acc SHALL be 0 and y SHALL be 0, asynchronously.
REQ-028 Reset asserted mid-stream SHALL discard all in-flight beats.
REQ-029 In the first cycle after rst falls, in_ready SHALL be 1.
REQ-030 Data registers other than y MAY be non-reset.

Structure
REQ-031 A shared package karatsuba_pkg SHALL hold:
- the default W and POLY;
- the width localparams (PW = 2W-1, YW = 4W-1);
- a clmul function used by the reduction.
REQ-032 The reduction SHALL be one combinational sub-module, gf2_reduce (parameters W, POLY), instantiated in stage 2.
REQ-033 The two pipeline stages, the handshake and the accumulator SHALL reside in karatsuba_combine_pipe.

Verification (W=32, POLY=0x1B)
REQ-034 z0=1, z1=0, z2=0, mode=0 -> y=0x1_0000_0001 exactly 2 cycles after acceptance.
REQ-035 z0=0, z1=0, z2=1, mode=1, acc_en=0 -> y=0x1_0000_001B.
REQ-036 Two back-to-back beats with z0=1, z1=z2=0, mode=1, acc_en=1, first beat with acc_clr=1 -> outputs 0x1_0000_0001 then 0, and final acc=0.
REQ-037 Random stream with out_ready toggled randomly -> outputs match the reference model in order, y holds while stalled, no loss or duplication.
REQ-038 rst pulsed while both stages hold beats -> out_valid=0 and acc=0 immediately; the next beat after release yields a fresh result with acc starting from 0.
REQ-039 Continuous in_valid and out_ready=1 for 100 cycles -> in_ready=1 throughout and 100 outputs delivered in consecutive cycles.
